// File: rtl/mac_tc_reg.sv
// Multiply-accumulate core: MAC = A*B + C, unsigned or two's complement by TC.
// Combinational result plus a one-cycle registered copy with sync reset.
module mac_tc_reg #(
  parameter int A_width = 10,
  parameter int B_width = 10,
  localparam int P_width = A_width + B_width
) (
  input  logic               MAC_ACC_CLK,
  input  logic               acc_ff_rst,
  input  logic               EN,
  input  logic [A_width-1:0] A,
  input  logic [B_width-1:0] B,
  input  logic [P_width-1:0] C,
  input  logic               TC,
  output logic [P_width-1:0] MAC,
  output logic [P_width-1:0] MAC_Q
);

  logic [P_width-1:0] a_ext;
  logic [P_width-1:0] b_ext;
  logic [P_width-1:0] prod;
  logic               a_fill;
  logic               b_fill;

  assign a_fill = TC & A[A_width-1];
  assign b_fill = TC & B[B_width-1];

  assign a_ext = {{B_width{a_fill}}, A};
  assign b_ext = {{A_width{b_fill}}, B};

  // Product of the extended operands modulo 2^P_width is exact in both modes.
  always_comb begin
    prod = '0;
    for (int i = 0; i < P_width; i++) begin
      if (b_ext[i]) begin
        prod = prod + (a_ext << i);
      end
    end
  end

  assign MAC = prod + C;

  always_ff @(posedge MAC_ACC_CLK) begin
    if (acc_ff_rst) begin
      MAC_Q <= '0;
    end else if (EN) begin
      MAC_Q <= MAC;
    end
  end

endmodule

// File: tb/tb_mac_tc_reg.sv
// Randomized and directed bench for mac_tc_reg against an arithmetic model.
module tb_mac_tc_reg;

  logic        clk;
  logic        rst;
  logic        en;
  logic [9:0]  a;
  logic [9:0]  b;
  logic [19:0] c;
  logic        tc;
  logic [19:0] mac;
  logic [19:0] mac_q;

  int checks = 0;
  int errors = 0;
  logic [19:0] q_exp;

  mac_tc_reg #(.A_width(10), .B_width(10)) dut (
    .MAC_ACC_CLK(clk),
    .acc_ff_rst (rst),
    .EN         (en),
    .A          (a),
    .B          (b),
    .C          (c),
    .TC         (tc),
    .MAC        (mac),
    .MAC_Q      (mac_q)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] got,
                       input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_mac(input logic [9:0] ai,
                                          input logic [9:0] bi,
                                          input logic [19:0] ci,
                                          input logic ti);
    longint sa;
    longint sb;
    longint r;
    sa = longint'(ai);
    sb = longint'(bi);
    if (ti && ai[9]) sa = sa - 1024;
    if (ti && bi[9]) sb = sb - 1024;
    r = sa * sb + longint'(ci);
    return r[19:0];
  endfunction

  task automatic apply(input logic [9:0] ai, input logic [9:0] bi,
                       input logic [19:0] ci, input logic ti,
                       input logic ei, input logic ri);
    logic [19:0] m;
    a = ai; b = bi; c = ci; tc = ti; en = ei; rst = ri;
    m = ref_mac(ai, bi, ci, ti);
    #1;
    check("mac", mac, m);
    @(posedge clk);
    if (ri) q_exp = '0;
    else if (ei) q_exp = m;
    @(negedge clk);
    check("mac_q", mac_q, q_exp);
  endtask

  logic [19:0] fb_exp [4];

  initial begin
    fb_exp[0] = 20'hFFFFD;
    fb_exp[1] = 20'hFFFFA;
    fb_exp[2] = 20'hFFFF7;
    fb_exp[3] = 20'hFFFF4;
    q_exp = '0;
    a = 0; b = 0; c = 0; tc = 0; en = 0; rst = 1;
    @(negedge clk);
    apply(10'd0, 10'd0, 20'd0, 1'b0, 1'b1, 1'b1);
    check("reset_q", mac_q, 20'h00000);

    apply(10'd15, 10'd15, 20'd0, 1'b0, 1'b1, 1'b0);
    check("unsigned_q", mac_q, 20'h000E1);
    check("unsigned", mac, 20'd225);

    apply(10'h3F8, 10'd7, 20'd0, 1'b1, 1'b1, 1'b0);
    check("signed", mac, 20'hFFFC8);
    tc = 0; #1;
    check("tc_live", mac, 20'h01BC8);

    apply(10'h3FF, 10'h3FF, 20'hFFFFF, 1'b0, 1'b1, 1'b0);
    check("wrap_u", mac, 20'hFF800);
    apply(10'h3FF, 10'h3FF, 20'hFFFFF, 1'b1, 1'b1, 1'b0);
    check("wrap_s", mac, 20'h00000);

    apply(10'h3F9, 10'h005, 20'd40, 1'b1, 1'b1, 1'b0);
    check("sext", mac, 20'h00005);

    apply(10'd0, 10'h2A5, 20'h12345, 1'b1, 1'b0, 1'b0);
    check("zero_c", mac, 20'h12345);

    apply(10'd0, 10'd0, 20'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply(10'h3FF, 10'd3, q_exp, 1'b1, 1'b1, 1'b0);
      check("feedback", mac_q, fb_exp[i]);
    end

    for (int i = 0; i < 3; i++) begin
      apply(10'($urandom), 10'($urandom), 20'($urandom),
            1'($urandom), 1'b0, 1'b0);
      check("hold", mac_q, 20'hFFFF4);
    end

    apply(10'd100, 10'd3, 20'd5, 1'b0, 1'b1, 1'b1);
    check("rst_pri", mac_q, 20'h00000);
    check("rst_live", mac, 20'd305);
    apply(10'd100, 10'd3, 20'd6, 1'b0, 1'b1, 1'b0);
    check("post_rst", mac_q, 20'd306);

    for (int i = 0; i < 300; i++) begin
      apply(10'($urandom), 10'($urandom), 20'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tc_reg.md
Name: mac_tc_reg

Overview:
- Parameterised multiply-accumulate datapath: MAC = A*B + C, in unsigned or two's-complement mode selected at run time by TC.
- Drop-in compute core for the eFPGA math-unit accumulators (e.g. the 4-bit MAC slice feeds sign-extended 10-bit operands and a 20-bit feedback accumulator).
- Provides a combinational result for feedback use and a one-cycle registered result.

Parameters:
- A_width, 10, width of multiplicand A (min 2).
- B_width, 10, width of multiplier B (min 2).
- Derived: P_width = A_width + B_width, width of C, MAC and MAC_Q.

Ports:
- MAC_ACC_CLK  input  1  sole clock; all state updates on rising edge.
- acc_ff_rst  input  1  reset, synchronous, active-high.
- EN  input  1  load enable for the output register.
- A  input  A_width  multiplicand.
- B  input  B_width  multiplier.
- C  input  P_width  addend / accumulator feedback.
- TC  input  1  0 = all operands unsigned, 1 = all operands two's complement.
- MAC  output  P_width  combinational A*B + C.
- MAC_Q  output  P_width  registered copy of MAC.

Behaviour:
- Interface: one clock, MAC_ACC_CLK; reset acc_ff_rst is synchronous and active-high.
- MAC is purely combinational from A, B, C and TC; no clock or reset dependence.
- TC=0: A, B and C are zero-extended; the full product is P_width bits unsigned.
- TC=1: A, B and C are sign-extended; the signed product fits exactly in P_width bits.
- Sum = product + C, truncated modulo 2^P_width, with no saturation and no overflow flag.
- Wrap-around in both modes is silent; the low P_width bits are the result.
- The result bit pattern is identical for any TC where the low P_width bits coincide. Example: 0*x + C = C.
- Operands already sign-extended by the caller (upper bits = sign) must give the same product as the narrower signed operation.
- MAC_Q register:
  - acc_ff_rst=1 at a rising edge: MAC_Q <= 0. Reset has priority over EN.
  - Otherwise EN=1: MAC_Q <= MAC.
  - Otherwise EN=0: MAC_Q holds.
- Latency: MAC is 0 cycles; MAC_Q is 1 cycle.
- Reset value: MAC_Q = 0. MAC has no reset value and follows its inputs even while in reset.
- Reset mid-stream: the pending result is discarded; the next enabled edge after reset deasserts loads a fresh MAC.
- TC change takes effect immediately on MAC; it is never registered.
- X/undefined inputs need not be handled. Synthesis must not infer latches.
- Implementation uses a synthesizable multiplier: an explicit partial-product array or the * operator on properly sign-extended P_width operands.

Test Plan (A_width=B_width=10):
- Unsigned: TC=0, A=15, B=15, C=0, EN=1 -> MAC=225 immediately; MAC_Q=20'h000E1 after 1 edge.
- Signed: TC=1, A=10'h3F8 (-8), B=7, C=0 -> MAC=20'hFFFC8 (-56). Same operands with TC=0 -> MAC=20'h01BC8 (7112).
- Accumulate with wrap: TC=0, A=B=10'h3FF, C=20'hFFFFF -> MAC=20'hFF800 (1046529+1048575 mod 2^20). TC=1, same A, B, C -> (-1)(-1)+(-1) = 20'h00000.
- Feedback loop: C driven from MAC_Q, TC=1, A=10'h3FF (-1), B=3, EN=1 for 4 edges from reset -> MAC_Q = 20'hFFFFD, FFFFA, FFFF7, FFFF4.
- Enable/reset: EN=0 for 3 edges with changing inputs -> MAC_Q holds. acc_ff_rst=1 with EN=1 -> MAC_Q=0 at that edge while MAC still shows the live result. After reset deasserts, first EN=1 edge loads the new MAC.
- Sign-extended operands: TC=1, A={6{1},4'h9} (-7), B={6{0},4'h5} (5), C=20'd40 -> MAC=20'h00005.
